// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
// funct3 codes, exception causes, state encoding and common constants.
package mem_access_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-bus req/ack interface between the memory stage and the data memory.
// master = memory stage, slave = memory/bus fabric.
interface mem_access_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );

endinterface

// File: rtl/mem_load_align.sv
// Load data lane selection and sign/zero extension.
// Purely combinational; word loads pass straight through.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] word
);

    logic [7:0]  b;
    logic [15:0] h;

    // pick the addressed byte/halfword, then extend by funct3
    always_comb begin
        b    = 8'h00;
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        word = rdata;
        case (off)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        case (funct3)
            LB:  word = {{24{b[7]}}, b};
            LH:  word = {{16{h[15]}}, h};
            LBU: word = {24'h0, b};
            LHU: word = {16'h0, h};
            default: word = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage with integrated MEM/WB register.
// Optional bus-ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic                  mem_rd_i,
    input  logic                  mem_wr_i,
    input  logic [2:0]            mem_funct3_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_sdata_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  wb_we_o,
    output logic [REG_ADDR_W-1:0] wb_waddr_o,
    output logic [31:0]           wb_wdata_o,
    mem_access_if.master          bus,
    output logic                  exc_o,
    output logic [1:0]            exc_cause_o
);

    import mem_access_pkg::*;

    state_t state_q, state_d;

    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  ld_q, ld_d;
    logic                  drop_q, drop_d;

    logic                  wb_we_d;
    logic [REG_ADDR_W-1:0] wb_waddr_d;
    logic [31:0]           wb_wdata_d;
    logic                  req_d;
    logic                  we_d;
    logic [31:0]           addr_d;
    logic [3:0]            be_d;
    logic [31:0]           wdat_d;
    logic                  exc_d;
    logic [1:0]            cause_d;

    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic        is_mem;
    logic        ld_ok;
    logic        st_ok;
    logic        illegal;
    logic        misal;
    logic [31:0] ld_word;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    mem_load_align u_align (
        .rdata  (bus.mem_rdata_i),
        .off    (off_q),
        .funct3 (f3_q),
        .word   (ld_word)
    );

    // decode legality and alignment of the incoming memory op
    always_comb begin
        is_mem  = mem_rd_i | mem_wr_i;
        ld_ok   = mem_funct3_i inside {LB, LH, LW, LBU, LHU};
        st_ok   = mem_funct3_i inside {SB, SH, SW};
        illegal = (mem_rd_i & mem_wr_i)
                | (mem_rd_i & ~ld_ok)
                | (mem_wr_i & ~st_ok);
        misal   = ((mem_funct3_i[1:0] == 2'b01) & mem_addr_i[0])
                | ((mem_funct3_i[1:0] == 2'b10) & (mem_addr_i[1:0] != 2'b00));
    end

    // store byte-lane steering and data replication
    always_comb begin
        be_s = 4'b0000;
        wd_s = ZeroWord;
        if (mem_wr_i) begin
            case (mem_funct3_i[1:0])
                2'b00: begin
                    be_s = 4'b0001 << mem_addr_i[1:0];
                    wd_s = {4{mem_sdata_i[7:0]}};
                end
                2'b01: begin
                    be_s = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                    wd_s = {2{mem_sdata_i[15:0]}};
                end
                default: begin
                    be_s = 4'b1111;
                    wd_s = mem_sdata_i;
                end
            endcase
        end
    end

    // next-state, stall and next register values
    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        ld_d       = ld_q;
        drop_d     = drop_q;
        wb_we_d    = ~WriteEnable;
        wb_waddr_d = wb_waddr_o;
        wb_wdata_d = wb_wdata_o;
        req_d      = bus.mem_req_o;
        we_d       = bus.mem_we_o;
        addr_d     = bus.mem_addr_o;
        be_d       = bus.mem_be_o;
        wdat_d     = bus.mem_wdata_o;
        exc_d      = 1'b0;
        cause_d    = exc_cause_o;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    if (!is_mem) begin
                        wb_we_d    = wreg_i;
                        wb_waddr_d = wd_i;
                        wb_wdata_d = wdata_i;
                    end else if (illegal) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_ILLEGAL;
                    end else if (misal) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_MISALIGN;
                    end else begin
                        stallreq_o = 1'b1;
                        f3_d       = mem_funct3_i;
                        off_d      = mem_addr_i[1:0];
                        rd_d       = wd_i;
                        ld_d       = mem_rd_i;
                        drop_d     = 1'b0;
                        req_d      = 1'b1;
                        we_d       = mem_wr_i;
                        addr_d     = {mem_addr_i[31:2], 2'b00};
                        be_d       = mem_wr_i ? be_s : 4'b1111;
                        wdat_d     = wd_s;
                        state_d    = BUSY;
`ifdef MEM_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            BUSY: begin
                stallreq_o = 1'b1;
                drop_d     = drop_q | flush_i;
                if (bus.mem_ack_i) begin
                    stallreq_o = 1'b0;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    if (ld_q && !(drop_q || flush_i)) begin
                        wb_we_d    = WriteEnable;
                        wb_waddr_d = rd_q;
                        wb_wdata_d = ld_word;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TERM) begin
                    stallreq_o = 1'b0;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    exc_d      = 1'b1;
                    cause_d    = EXC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state, latches, bus outputs and MEM/WB register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q         <= IDLE;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            rd_q            <= '0;
            ld_q            <= 1'b0;
            drop_q          <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_waddr_o      <= '0;
            wb_wdata_o      <= ZeroWord;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= ZeroWord;
            bus.mem_be_o    <= 4'b0000;
            bus.mem_wdata_o <= ZeroWord;
            exc_o           <= 1'b0;
            exc_cause_o     <= EXC_NONE;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            f3_q            <= f3_d;
            off_q           <= off_d;
            rd_q            <= rd_d;
            ld_q            <= ld_d;
            drop_q          <= drop_d;
            wb_we_o         <= wb_we_d;
            wb_waddr_o      <= wb_waddr_d;
            wb_wdata_o      <= wb_wdata_d;
            bus.mem_req_o   <= req_d;
            bus.mem_we_o    <= we_d;
            bus.mem_addr_o  <= addr_d;
            bus.mem_be_o    <= be_d;
            bus.mem_wdata_o <= wdat_d;
            exc_o           <= exc_d;
            exc_cause_o     <= cause_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access with a write-back scoreboard.
// Timeout scenario is covered when MEM_TIMEOUT_EN is defined.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    mem_access_if bus ();

    mem_access #(
        .TIMEOUT_CYCLES (4),
        .REG_ADDR_W     (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .mem_funct3_i (mem_funct3_i),
        .mem_addr_i   (mem_addr_i),
        .mem_sdata_i  (mem_sdata_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .wb_we_o      (wb_we_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .bus          (bus),
        .exc_o        (exc_o),
        .exc_cause_o  (exc_cause_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        dchk;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_we"}, {31'd0, wb_we_o}, {31'd0, e.we});
            if (e.dchk) begin
                chk({tag, "_waddr"}, {27'd0, wb_waddr_o}, {27'd0, e.waddr});
                chk({tag, "_wdata"}, wb_wdata_o, e.wdata);
            end
        end
    endtask

    task automatic idle_in();
        valid_i  = 1'b0;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        flush_i  = 1'b0;
        wreg_i   = 1'b0;
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [4:0] d);
        valid_i      = 1'b1;
        mem_rd_i     = rd;
        mem_wr_i     = wr;
        mem_funct3_i = f3;
        mem_addr_i   = a;
        wd_i         = d;
        wreg_i       = rd;
    endtask

    initial begin
        rst             = 1'b1;
        idle_in();
        wd_i            = '0;
        wdata_i         = '0;
        mem_funct3_i    = '0;
        mem_addr_i      = '0;
        mem_sdata_i     = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_exc", {31'd0, exc_o}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);

        // ALU op
        valid_i = 1'b1; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
        #1;
        chk("alu_stall", {31'd0, stallreq_o}, 32'd0);
        q.push_back('{1'b1, 1'b1, 5'd5, 32'h1234});
        tick();
        idle_in();
        wb_check("alu");
        tick();
        chk("idle_we", {31'd0, wb_we_o}, 32'd0);

        // lb at 0x103, ack after 3 waiting cycles
        mem_op(1'b1, 1'b0, 3'b000, 32'h103, 5'd7);
        #1;
        n = 0;
        if (stallreq_o) n++;
        q.push_back('{1'b1, 1'b1, 5'd7, 32'hFFFF_FF80});
        tick();
        chk("lb_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("lb_addr", bus.mem_addr_o, 32'h100);
        chk("lb_we", {31'd0, bus.mem_we_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (stallreq_o) n++;
            tick();
        end
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h80AA_BBCC;
        #1;
        chk("lb_ack_stall", {31'd0, stallreq_o}, 32'd0);
        chk("lb_stall_cycles", n, 32'd4);
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();
        wb_check("lb");
        chk("lb_req_drop", {31'd0, bus.mem_req_o}, 32'd0);

        // lhu at 0x102, zero-wait ack
        mem_op(1'b1, 1'b0, 3'b101, 32'h102, 5'd9);
        #1;
        chk("lhu_stall", {31'd0, stallreq_o}, 32'd1);
        q.push_back('{1'b1, 1'b1, 5'd9, 32'h0000_BEEF});
        tick();
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBEEF_0000;
        #1;
        chk("lhu_ack_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();
        wb_check("lhu");

        // sh at 0x202
        mem_op(1'b0, 1'b1, 3'b001, 32'h202, 5'd3);
        mem_sdata_i = 32'h1234_ABCD;
        q.push_back('{1'b0, 1'b0, 5'd0, 32'h0});
        tick();
        chk("sh_we", {31'd0, bus.mem_we_o}, 32'd1);
        chk("sh_be", {28'd0, bus.mem_be_o}, 32'hC);
        chk("sh_wdata", bus.mem_wdata_o, 32'hABCD_ABCD);
        chk("sh_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();
        wb_check("sh");

        // sb at 0x103
        mem_op(1'b0, 1'b1, 3'b000, 32'h103, 5'd0);
        mem_sdata_i = 32'h0000_005A;
        tick();
        chk("sb_be", {28'd0, bus.mem_be_o}, 32'h8);
        chk("sb_wdata", bus.mem_wdata_o, 32'h5A5A_5A5A);
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();

        // misaligned lw at 0x101
        mem_op(1'b1, 1'b0, 3'b010, 32'h101, 5'd4);
        #1;
        chk("mis_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        idle_in();
        chk("mis_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("mis_exc", {31'd0, exc_o}, 32'd1);
        chk("mis_cause", {30'd0, exc_cause_o}, 32'd1);
        chk("mis_wbwe", {31'd0, wb_we_o}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, exc_o}, 32'd0);

        // rd and wr together
        mem_op(1'b1, 1'b1, 3'b000, 32'h0, 5'd4);
        tick();
        idle_in();
        chk("ill_exc", {31'd0, exc_o}, 32'd1);
        chk("ill_cause", {30'd0, exc_cause_o}, 32'd2);
        tick();
        chk("ill_pulse", {31'd0, exc_o}, 32'd0);

        // illegal load funct3
        mem_op(1'b1, 1'b0, 3'b011, 32'h0, 5'd4);
        tick();
        idle_in();
        chk("ill3_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("ill3_cause", {30'd0, exc_cause_o}, 32'd2);

        // flush while BUSY drops the load write-back
        mem_op(1'b1, 1'b0, 3'b010, 32'h40, 5'd6);
        q.push_back('{1'b0, 1'b0, 5'd0, 32'h0});
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_req", {31'd0, bus.mem_req_o}, 32'd1);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();
        wb_check("flush");

        // ack while IDLE is ignored
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk("stray_ack_we", {31'd0, wb_we_o}, 32'd0);
        chk("stray_ack_req", {31'd0, bus.mem_req_o}, 32'd0);

        // reset during BUSY
        mem_op(1'b0, 1'b1, 3'b010, 32'h300, 5'd2);
        mem_sdata_i = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        idle_in();
        tick();
        rst = 1'b0;
        #1;
        chk("rb_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rb_we", {31'd0, bus.mem_we_o}, 32'd0);
        chk("rb_addr", bus.mem_addr_o, 32'd0);
        chk("rb_be", {28'd0, bus.mem_be_o}, 32'd0);
        chk("rb_wdata", bus.mem_wdata_o, 32'd0);
        chk("rb_wbwdata", wb_wdata_o, 32'd0);
        chk("rb_cause", {30'd0, exc_cause_o}, 32'd0);
        chk("rb_idle", {31'd0, stallreq_o}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        mem_op(1'b1, 1'b0, 3'b010, 32'h400, 5'd8);
        tick();
        idle_in();
        n = 0;
        while (bus.mem_req_o && n < 10) begin
            n++;
            tick();
        end
        chk("to_busy_cycles", n, 32'd4);
        chk("to_exc", {31'd0, exc_o}, 32'd1);
        chk("to_cause", {30'd0, exc_cause_o}, 32'd3);
        chk("to_wbwe", {31'd0, wb_we_o}, 32'd0);
`else
        mem_op(1'b1, 1'b0, 3'b010, 32'h400, 5'd8);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("nto_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("nto_stall", {31'd0, stallreq_o}, 32'd1);
        q.push_back('{1'b1, 1'b1, 5'd8, 32'h1122_3344});
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1122_3344;
        tick();
        bus.mem_ack_i = 1'b0;
        idle_in();
        wb_check("nto_lw");
`endif

        chk("sb_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
